tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen_pkg.sv | 16 +
 rtl/sync_2ff.sv | 28 ++
 rtl/tick_gen.sv | 111 +++++++++++
 tb/tb_tick_gen.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// tick_gen shared types and defaults
// FSM state encoding and default tick periods
package tick_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned     DEF_NB_COUNTER = 32;
  localparam longint unsigned DEF_LIMIT_0    = 4;
  localparam longint unsigned DEF_LIMIT_1    = 8;
  localparam longint unsigned DEF_LIMIT_2    = 16;
  localparam longint unsigned DEF_LIMIT_3    = 32;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer bank
// Brings asynchronous switch/button levels into the clock domain
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // first flop may go metastable, second one resolves it
  always_ff @(posedge clock) begin
    if (i_reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/tick_gen.sv
// tick_gen: free-running or single-step tick source
// Drives a one-clock o_valid pulse at a selectable period
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int              NB_COUNTER = DEF_NB_COUNTER,
  parameter longint unsigned LIMIT_0    = DEF_LIMIT_0,
  parameter longint unsigned LIMIT_1    = DEF_LIMIT_1,
  parameter longint unsigned LIMIT_2    = DEF_LIMIT_2,
  parameter longint unsigned LIMIT_3    = DEF_LIMIT_3
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_sel,
  input  logic       i_step,
  output logic       o_valid,
  output logic       o_run
);

  localparam logic [NB_COUNTER-1:0] LM1_0 =
    NB_COUNTER'(LIMIT_0 - 64'd1);
  localparam logic [NB_COUNTER-1:0] LM1_1 =
    NB_COUNTER'(LIMIT_1 - 64'd1);
  localparam logic [NB_COUNTER-1:0] LM1_2 =
    NB_COUNTER'(LIMIT_2 - 64'd1);
  localparam logic [NB_COUNTER-1:0] LM1_3 =
    NB_COUNTER'(LIMIT_3 - 64'd1);

  logic [3:0] sync_in;
  logic [3:0] sync_out;
  logic       en_s;
  logic [1:0] sel_s;
  logic       step_s;

  state_t                  state_q, state_d;
  logic [NB_COUNTER-1:0]   cnt_q, cnt_d;
  logic [NB_COUNTER-1:0]   lim_m1;
  logic                    valid_q, valid_d;
  logic                    step_q;

  assign sync_in = {i_step, i_sel, i_enable};

  sync_2ff #(
    .W(4)
  ) u_sync (
    .clock  (clock),
    .i_reset(i_reset),
    .i_d    (sync_in),
    .o_q    (sync_out)
  );

  assign en_s   = sync_out[0];
  assign sel_s  = sync_out[2:1];
  assign step_s = sync_out[3];

  // terminal count for the selected period, used live so a
  // shorter period takes effect without overrunning
  always_comb begin
    lim_m1 = LM1_0;
    unique case (sel_s)
      2'd0: lim_m1 = LM1_0;
      2'd1: lim_m1 = LM1_1;
      2'd2: lim_m1 = LM1_2;
      2'd3: lim_m1 = LM1_3;
    endcase
  end

  // next state, counter and pulse request
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (step_s && !step_q) valid_d = 1'b1;
        if (en_s) state_d = RUN;
      end
      RUN: begin
        if (!en_s) begin
          state_d = IDLE;
        end else if (cnt_q >= lim_m1) begin
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + NB_COUNTER'(1);
        end
      end
    endcase
  end

  // state, counter, registered pulse and step history;
  // step history runs in every state so a press held
  // through RUN is not seen as a new edge in IDLE
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      step_q  <= step_s;
    end
  end

  assign o_valid = valid_q;
  assign o_run   = (state_q == RUN);

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: scoreboard bench for tick_gen
// Expected pulse cycles are queued by each scenario
module tb_tick_gen;

  logic       clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_enable = 1'b0;
  logic [1:0] i_sel = 2'd0;
  logic       i_step = 1'b0;
  logic       o_valid;
  logic       o_run;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_q[$];
  bit mon_en = 1'b1;

  logic [3:0] led;
  logic [3:0] pat [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  tick_gen dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_enable(i_enable),
    .i_sel   (i_sel),
    .i_step  (i_step),
    .o_valid (o_valid),
    .o_run   (o_run)
  );

  always #5 clock = ~clock;

  // posedge counter used as the time base
  always @(posedge clock) cyc <= cyc + 1;

  // downstream 4-LED rotating shifter
  always @(posedge clock) begin
    if (i_reset) led <= 4'b0001;
    else if (o_valid) led <= {led[2:0], led[3]};
  end

  // every pulse must match the next queued cycle
  always @(negedge clock) begin
    if (mon_en && o_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected: got pulse at cyc %0d want none",
                 cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc !== e) begin
          bad++;
          $display("FAIL pulse_time: got cyc %0d want cyc %0d", cyc, e);
        end
      end
    end
  end

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    to_cyc(cyc + 3);
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid: got %b want 0", o_valid);
    end
    total++;
    if (o_run !== 1'b0) begin
      bad++;
      $display("FAIL rst_run: got %b want 0", o_run);
    end
    total++;
    if (dut.cnt_q !== 0) begin
      bad++;
      $display("FAIL rst_cnt: got %0d want 0", dut.cnt_q);
    end
    total++;
    if (dut.u_sync.o_q !== 4'b0) begin
      bad++;
      $display("FAIL rst_sync: got %b want 0000", dut.u_sync.o_q);
    end
    i_reset = 1'b0;
    to_cyc(cyc + 2);
  endtask

  task automatic test_free_run;
    int r;
    r = cyc + 3;
    i_sel = 2'd0;
    i_enable = 1'b1;
    for (int k = 1; k <= 6; k++) exp_q.push_back(r + 4 * k);
    to_cyc(r - 1);
    total++;
    if (o_run !== 1'b0) begin
      bad++;
      $display("FAIL run_early: got %b want 0", o_run);
    end
    to_cyc(r);
    total++;
    if (o_run !== 1'b1) begin
      bad++;
      $display("FAIL run_entry: got %b want 1", o_run);
    end
    for (int k = 1; k <= 5; k++) begin
      to_cyc(r + 4 * k + 1);
      total++;
      if (led !== pat[k % 4]) begin
        bad++;
        $display("FAIL led_step%0d: got %b want %b", k, led, pat[k % 4]);
      end
    end
    to_cyc(r + 22);
    i_enable = 1'b0;
    to_cyc(r + 30);
    total++;
    if (o_run !== 1'b0) begin
      bad++;
      $display("FAIL run_exit: got %b want 0", o_run);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL free_missing: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_sel_change;
    int r;
    r = cyc + 3;
    i_sel = 2'd3;
    i_enable = 1'b1;
    exp_q.push_back(r + 21);
    exp_q.push_back(r + 25);
    exp_q.push_back(r + 29);
    to_cyc(r + 18);
    i_sel = 2'd0;
    to_cyc(r + 20);
    total++;
    if (dut.cnt_q !== 20) begin
      bad++;
      $display("FAIL sel_cnt20: got %0d want 20", dut.cnt_q);
    end
    to_cyc(r + 29);
    i_enable = 1'b0;
    to_cyc(r + 36);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sel_missing: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_step;
    int n;
    int p;
    n = cyc;
    i_step = 1'b1;
    exp_q.push_back(n + 3);
    to_cyc(n + 10);
    i_step = 1'b0;
    to_cyc(n + 15);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL step1_missing: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
    p = cyc;
    i_step = 1'b1;
    exp_q.push_back(p + 3);
    to_cyc(p + 6);
    i_step = 1'b0;
    to_cyc(p + 10);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL step2_missing: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_enable_drop;
    int r;
    int r2;
    r = cyc + 3;
    i_sel = 2'd1;
    i_enable = 1'b1;
    to_cyc(r + 3);
    i_enable = 1'b0;
    to_cyc(r + 5);
    total++;
    if (dut.cnt_q !== 5 || o_run !== 1'b1) begin
      bad++;
      $display("FAIL drop_pre: got cnt %0d run %b want cnt 5 run 1",
               dut.cnt_q, o_run);
    end
    to_cyc(r + 6);
    total++;
    if (dut.cnt_q !== 0 || o_run !== 1'b0) begin
      bad++;
      $display("FAIL drop_post: got cnt %0d run %b want cnt 0 run 0",
               dut.cnt_q, o_run);
    end
    to_cyc(r + 7);
    i_enable = 1'b1;
    r2 = r + 10;
    exp_q.push_back(r2 + 8);
    to_cyc(r2 + 9);
    i_enable = 1'b0;
    to_cyc(r2 + 16);
    total++;
    if (exp_q.size() != 0 || o_run !== 1'b0) begin
      bad++;
      $display("FAIL reenable: got %0d left run %b want 0 left run 0",
               exp_q.size(), o_run);
      exp_q.delete();
    end
  endtask

  task automatic test_step_in_run;
    int r;
    r = cyc + 3;
    i_sel = 2'd0;
    i_enable = 1'b1;
    exp_q.push_back(r + 4);
    exp_q.push_back(r + 8);
    to_cyc(r + 1);
    i_step = 1'b1;
    to_cyc(r + 8);
    i_enable = 1'b0;
    to_cyc(r + 20);
    total++;
    if (o_run !== 1'b0) begin
      bad++;
      $display("FAIL steprun_idle: got %b want 0", o_run);
    end
    i_step = 1'b0;
    to_cyc(r + 26);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL steprun_missing: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    int r;
    r = cyc + 3;
    i_sel = 2'd0;
    i_enable = 1'b1;
    to_cyc(r + 3);
    total++;
    if (dut.cnt_q !== 3) begin
      bad++;
      $display("FAIL rmid_cnt: got %0d want 3", dut.cnt_q);
    end
    i_reset = 1'b1;
    i_enable = 1'b0;
    to_cyc(r + 4);
    total++;
    if (o_valid !== 1'b0 || o_run !== 1'b0) begin
      bad++;
      $display("FAIL rmid_out: got valid %b run %b want 0 0",
               o_valid, o_run);
    end
    total++;
    if (dut.state_q !== tick_gen_pkg::IDLE) begin
      bad++;
      $display("FAIL rmid_state: got %b want IDLE", dut.state_q);
    end
    i_reset = 1'b0;
    to_cyc(r + 10);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rmid_queue: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_step_after_reset;
    int pulses;
    pulses = 0;
    i_step = 1'b1;
    i_reset = 1'b1;
    to_cyc(cyc + 2);
    mon_en = 1'b0;
    i_reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (o_valid === 1'b1) pulses++;
    end
    total++;
    if (pulses > 1) begin
      bad++;
      $display("FAIL step_after_rst: got %0d pulses want at most 1", pulses);
    end
    i_step = 1'b0;
    to_cyc(cyc + 4);
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_sel_change();
    test_step();
    test_enable_drop();
    test_step_in_run();
    test_reset_mid();
    test_step_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
